qracc_sram_ctrl: RTL and testbench



---
 rtl/qracc_sram_ctrl_pkg.sv | 28 ++
 rtl/qracc_wl_decoder.sv | 24 ++
 rtl/qracc_sram_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_qracc_sram_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qracc_sram_ctrl_pkg.sv
// Shared types and default timing for the QrAcc SRAM controller.
// Holds the FSM state encoding and a helper that sizes the phase counter.
package qracc_sram_ctrl_pkg;

  localparam int unsigned SRAM_NUM_ROWS   = 128;
  localparam int unsigned SRAM_NUM_COLS   = 32;
  localparam int unsigned SRAM_PCH_CYCLES = 2;
  localparam int unsigned SRAM_WL_CYCLES  = 2;
  localparam int unsigned SRAM_SA_CYCLES  = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRECH = 3'd1,
    WLON  = 3'd2,
    SENSE = 3'd3,
    DONE  = 3'd4
  } sram_ctrl_state_t;

  // Largest of three phase lengths; sizes the shared down-counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/qracc_wl_decoder.sv
// Binary-to-one-hot wordline decoder with enable and out-of-range guard.
// Purely combinational; the controller registers its output.
module qracc_wl_decoder #(
  parameter int unsigned numRows = 128
) (
  input  logic                       en_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  output logic [numRows-1:0]         wl_o_c,
  output logic                       in_range_o_c
);

  localparam int unsigned AW = $clog2(numRows);

  // Zero-extended compare so the guard stays meaningful when numRows is not a power of 2.
  assign in_range_o_c = ({1'b0, addr_i} < (AW + 1)'(numRows));

  always_comb begin
    wl_o_c = '0;
    for (int unsigned r = 0; r < numRows; r++) begin
      wl_o_c[r] = en_i && (addr_i == AW'(r));
    end
  end

endmodule

// File: rtl/qracc_sram_ctrl.sv
// SRAM request/response slave that sequences precharge, wordline, write and
// sense-amp controls of the analog macro, one row access at a time.
module qracc_sram_ctrl
  import qracc_sram_ctrl_pkg::*;
#(
  parameter int unsigned numRows    = SRAM_NUM_ROWS,
  parameter int unsigned numCols    = SRAM_NUM_COLS,
  parameter int unsigned PCH_CYCLES = SRAM_PCH_CYCLES,
  parameter int unsigned WL_CYCLES  = SRAM_WL_CYCLES,
  parameter int unsigned SA_CYCLES  = SRAM_SA_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rq_wr_i,
  input  logic                       rq_valid_i,
  output logic                       rq_ready_o,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  input  logic [numCols-1:0]         wr_data_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  output logic [numRows-1:0]         WL,
  output logic                       PCH,
  output logic [numCols-1:0]         WR_DATA,
  output logic                       WRITE,
  output logic [numCols-1:0]         CSEL,
  output logic                       SAEN,
  input  logic [numCols-1:0]         SA_OUT
);

  localparam int unsigned AW = $clog2(numRows);
  localparam int unsigned CW = $clog2(max3(PCH_CYCLES, WL_CYCLES, SA_CYCLES) + 1);

  if (PCH_CYCLES == 0 || WL_CYCLES == 0 || SA_CYCLES == 0) begin : g_bad_cycles
    $error("qracc_sram_ctrl: PCH_CYCLES, WL_CYCLES and SA_CYCLES must all be >= 1");
  end

  sram_ctrl_state_t state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [numCols-1:0] wdata_q, wdata_d;

  logic               ready_q, ready_d;
  logic               rd_valid_q, rd_valid_d;
  logic [numCols-1:0] rd_data_q, rd_data_d;
  logic [numRows-1:0] wl_q;
  logic               pch_q, pch_d;
  logic               write_q, write_d;
  logic [numCols-1:0] wr_data_q, wr_data_d;
  logic [numCols-1:0] csel_q, csel_d;
  logic               saen_q, saen_d;

  logic               wl_en_d;
  logic [numRows-1:0] wl_dec_c;
  logic               in_range_c;

  // Decoder works from the latched address; enable is the next-cycle wordline phase.
  qracc_wl_decoder #(
    .numRows(numRows)
  ) u_wl_decoder (
    .en_i        (wl_en_d),
    .addr_i      (addr_q),
    .wl_o_c      (wl_dec_c),
    .in_range_o_c(in_range_c)
  );

  // Next-state and next-output logic; analog controls are registered so they
  // line up with the state they belong to.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;

    unique case (state_q)
      IDLE: begin
        if (rq_valid_i && ready_q) begin
          wr_d    = rq_wr_i;
          addr_d  = addr_i;
          wdata_d = wr_data_i;
          state_d = PRECH;
          cnt_d   = CW'(PCH_CYCLES - 1);
        end
      end
      PRECH: begin
        if (cnt_q == '0) begin
          state_d = WLON;
          cnt_d   = CW'(WL_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WLON: begin
        if (cnt_q == '0) begin
          if (wr_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = SENSE;
            cnt_d   = CW'(SA_CYCLES - 1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SENSE: begin
        if (cnt_q == '0) begin
          state_d   = DONE;
          // Out-of-range rows never fire a wordline, so report zeros instead of SA_OUT.
          rd_data_d = in_range_c ? SA_OUT : '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    ready_d    = (state_d == IDLE);
    rd_valid_d = (state_d == DONE);
    pch_d      = (state_d == PRECH);
    wl_en_d    = (state_d == WLON) || (state_d == SENSE);
    write_d    = (state_d == WLON) && wr_d;
    wr_data_d  = write_d ? wdata_d : '0;
    csel_d     = wl_en_d ? '1 : '0;
    saen_d     = (state_d == SENSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wl_q       <= '0;
      pch_q      <= 1'b0;
      write_q    <= 1'b0;
      wr_data_q  <= '0;
      csel_q     <= '0;
      saen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      wl_q       <= wl_dec_c;
      pch_q      <= pch_d;
      write_q    <= write_d;
      wr_data_q  <= wr_data_d;
      csel_q     <= csel_d;
      saen_q     <= saen_d;
    end
  end

  assign rq_ready_o = ready_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign WL         = wl_q;
  assign PCH        = pch_q;
  assign WRITE      = write_q;
  assign WR_DATA    = wr_data_q;
  assign CSEL       = csel_q;
  assign SAEN       = saen_q;

endmodule

// File: tb/tb_qracc_sram_ctrl.sv
// Bench for qracc_sram_ctrl: timeline reference model for the default
// instance plus directed latency/phase checks on a reparameterised instance.
module tb_qracc_sram_ctrl;

  localparam int unsigned NR  = 128;
  localparam int unsigned NC  = 32;
  localparam int unsigned NR2 = 100;
  localparam int P = 2;
  localparam int W = 2;
  localparam int S = 1;
  localparam time PER = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic          rst, rq_wr, rq_valid, rq_ready, rd_valid;
  logic [NC-1:0] rd_data, wr_data, wrd, csel, sa_out;
  logic [6:0]    addr;
  logic [NR-1:0] wl;
  logic          pch, write, saen;

  // sweep instance: 100 rows, PCH=1, WL=4, SA=3
  logic           rst2, rq_wr2, rq_valid2, rq_ready2, rd_valid2;
  logic [NC-1:0]  rd_data2, wr_data2, wrd2, csel2, sa_out2;
  logic [6:0]     addr2;
  logic [NR2-1:0] wl2;
  logic           pch2, write2, saen2;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  qracc_sram_ctrl dut (
    .clk(clk), .rst(rst), .rq_wr_i(rq_wr), .rq_valid_i(rq_valid), .rq_ready_o(rq_ready),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .wr_data_i(wr_data), .addr_i(addr),
    .WL(wl), .PCH(pch), .WR_DATA(wrd), .WRITE(write), .CSEL(csel), .SAEN(saen),
    .SA_OUT(sa_out)
  );

  qracc_sram_ctrl #(
    .numRows(NR2), .numCols(NC), .PCH_CYCLES(1), .WL_CYCLES(4), .SA_CYCLES(3)
  ) dut_sweep (
    .clk(clk), .rst(rst2), .rq_wr_i(rq_wr2), .rq_valid_i(rq_valid2), .rq_ready_o(rq_ready2),
    .rd_valid_o(rd_valid2), .rd_data_o(rd_data2), .wr_data_i(wr_data2), .addr_i(addr2),
    .WL(wl2), .PCH(pch2), .WR_DATA(wrd2), .WRITE(write2), .CSEL(csel2), .SAEN(saen2),
    .SA_OUT(sa_out2)
  );

  function automatic logic [NC-1:0] pat(input int r);
    return 32'hA500_0000 | NC'(r);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Analog macro model: rows written under WRITE&WL, read out under SAEN&WL.
  logic [NC-1:0] amem [NR];
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NR; r++) amem[r] <= pat(r);
    end else if (write) begin
      for (int r = 0; r < NR; r++) if (wl[r]) amem[r] <= wrd;
    end
  end
  always_comb begin
    sa_out = '0;
    if (saen) for (int r = 0; r < NR; r++) if (wl[r]) sa_out = amem[r];
  end
  assign sa_out2 = saen2 ? 32'hCAFE_F00D : '0;

  // Reference model: position k within an accepted access decides every output.
  logic          m_busy = 1'b0, m_ready = 1'b0, m_wr = 1'b0;
  int            m_k = 0;
  logic [6:0]    m_addr = '0;
  logic [NC-1:0] m_wdata = '0, m_rd_data = '0;
  logic [NC-1:0] mem_ref [NR];

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_ready <= 1'b0; m_rd_data <= '0; m_k <= 0;
      for (int r = 0; r < NR; r++) mem_ref[r] <= pat(r);
    end else if (!m_busy) begin
      m_ready <= 1'b1;
      if (rq_valid && m_ready) begin
        m_busy <= 1'b1; m_k <= 0; m_wr <= rq_wr; m_addr <= addr; m_wdata <= wr_data;
        if (rq_wr) mem_ref[addr] <= wr_data;
      end
    end else begin
      if (!m_wr && m_k == P + W + S - 1) m_rd_data <= mem_ref[m_addr];
      if (m_k == (m_wr ? P + W : P + W + S + 1) - 1) m_busy <= 1'b0;
      else m_k <= m_k + 1;
    end
  end

  logic          e_ready, e_pch, e_write, e_saen, e_rdv, e_inwl;
  logic [NR-1:0] e_wl;
  logic [NC-1:0] e_csel, e_wrd;
  always_comb begin
    e_ready = !m_busy && m_ready;
    e_pch   = m_busy && m_k < P;
    e_inwl  = m_busy && m_k >= P && m_k < P + W + (m_wr ? 0 : S);
    e_wl    = '0;
    if (e_inwl) e_wl[m_addr] = 1'b1;
    e_csel  = e_inwl ? '1 : '0;
    e_write = m_busy && m_wr && m_k >= P && m_k < P + W;
    e_wrd   = e_write ? m_wdata : '0;
    e_saen  = m_busy && !m_wr && m_k >= P + W && m_k < P + W + S;
    e_rdv   = m_busy && !m_wr && m_k == P + W + S;
  end

  logic prev_rdv = 1'b0, prev_rdv2 = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",   128'(rq_ready), 128'(e_ready));
      chk("rd_valid", 128'(rd_valid), 128'(e_rdv));
      chk("rd_data", 128'(rd_data),  128'(m_rd_data));
      chk("wl",      128'(wl),       128'(e_wl));
      chk("pch",     128'(pch),      128'(e_pch));
      chk("write",   128'(write),    128'(e_write));
      chk("wr_data", 128'(wrd),      128'(e_wrd));
      chk("csel",    128'(csel),     128'(e_csel));
      chk("saen",    128'(saen),     128'(e_saen));
      chk("p_pch_wl",    128'(pch & (|wl)),        128'(0));
      chk("p_write_sa",  128'(write & saen),       128'(0));
      chk("p_onehot",    128'($onehot0(wl)),       128'(1));
      chk("p_rdv_pulse", 128'(prev_rdv & rd_valid), 128'(0));
      chk("p2_pch_wl",    128'(pch2 & (|wl2)),         128'(0));
      chk("p2_write_sa",  128'(write2 & saen2),        128'(0));
      chk("p2_onehot",    128'($onehot0(wl2)),         128'(1));
      chk("p2_rdv_pulse", 128'(prev_rdv2 & rd_valid2), 128'(0));
    end
    prev_rdv  <= rd_valid;
    prev_rdv2 <= rd_valid2;
  end

  task automatic do_req(input bit d2, input logic wr, input logic [6:0] a,
                        input logic [31:0] d, input bit keep, output time t_acc);
    bit got = 1'b0;
    t_acc = 0;
    if (d2) begin rq_wr2 = wr; addr2 = a; wr_data2 = d; rq_valid2 = 1'b1; end
    else    begin rq_wr  = wr; addr  = a; wr_data  = d; rq_valid  = 1'b1; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = d2 ? rq_ready2 : rq_ready;
      @(posedge clk);
      if (got) t_acc = $time;
      #1;
    end
    chk("accepted", 128'(got), 128'(1));
    if (!keep) begin
      if (d2) rq_valid2 = 1'b0; else rq_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input bit d2);
    bit idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      idle = d2 ? rq_ready2 : rq_ready;
    end
    chk("idle_reached", 128'(idle), 128'(1));
  endtask

  task automatic read_wait(input bit d2, input time t_acc, output int lat, output int npch,
                           output int nwl, output int nsaen, output logic [31:0] data);
    bit done = 1'b0;
    lat = -1; npch = 0; nwl = 0; nsaen = 0; data = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (d2) begin
        npch += int'(pch2); nwl += int'(|wl2); nsaen += int'(saen2);
        if (rd_valid2) begin done = 1'b1; data = rd_data2; end
      end else begin
        npch += int'(pch); nwl += int'(wl[addr]); nsaen += int'(saen);
        if (rd_valid) begin done = 1'b1; data = rd_data; end
      end
      if (done) lat = int'(($time + PER / 2 - t_acc) / PER);
    end
    chk("rd_valid_seen", 128'(done), 128'(1));
  endtask

  time t1, t2;
  int lat, npch, nwl, nsaen;
  logic [31:0] data;

  initial begin
    rst = 1'b1; rq_valid = 1'b0; rq_wr = 1'b0; addr = '0; wr_data = '0;
    rst2 = 1'b1; rq_valid2 = 1'b0; rq_wr2 = 1'b0; addr2 = '0; wr_data2 = '0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready",   128'(rq_ready), 128'(0));
    chk("rst_wl",      128'(wl),       128'(0));
    chk("rst_rd_data", 128'(rd_data),  128'(0));
    chk("rst_pch",     128'(pch),      128'(0));
    @(posedge clk); #1;
    rst = 1'b0; rst2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_after_reset", 128'(rq_ready), 128'(1));

    // write then read back through the analog model
    do_req(1'b0, 1'b1, 7'd5, 32'hDEAD_BEEF, 1'b0, t1);
    wait_idle(1'b0);
    chk("amem5", 128'(amem[5]), 128'(32'hDEAD_BEEF));
    do_req(1'b0, 1'b0, 7'd5, 32'h0, 1'b0, t1);
    read_wait(1'b0, t1, lat, npch, nwl, nsaen, data);
    chk("t1_latency", 128'(lat),   128'(6));
    chk("t1_pch_cyc", 128'(npch),  128'(2));
    chk("t1_wl_cyc",  128'(nwl),   128'(3));
    chk("t1_sa_cyc",  128'(nsaen), 128'(1));
    chk("t1_data",    128'(data),  128'(32'hDEAD_BEEF));
    wait_idle(1'b0);

    // back-to-back writes with valid held
    do_req(1'b0, 1'b1, 7'd0,   32'h1111_1111, 1'b1, t1);
    do_req(1'b0, 1'b1, 7'd127, 32'h2222_2222, 1'b0, t2);
    chk("b2b_gap", 128'(int'((t2 - t1) / PER)), 128'(5));
    wait_idle(1'b0);
    do_req(1'b0, 1'b0, 7'd127, 32'h0, 1'b0, t1);
    read_wait(1'b0, t1, lat, npch, nwl, nsaen, data);
    chk("t2_data127", 128'(data), 128'(32'h2222_2222));
    wait_idle(1'b0);

    // inputs wiggle while busy; only the IDLE-time values count
    do_req(1'b0, 1'b1, 7'd10, 32'hAAAA_5555, 1'b0, t1);
    @(posedge clk); #1; addr = 7'd20; wr_data = 32'h1234_5678; rq_wr = 1'b0;
    @(posedge clk); #1; addr = 7'd33; wr_data = 32'h8765_4321;
    do_req(1'b0, 1'b1, 7'd20, 32'h5A5A_5A5A, 1'b0, t2);
    chk("busy_gap", 128'(int'((t2 - t1) / PER)), 128'(5));
    wait_idle(1'b0);
    do_req(1'b0, 1'b0, 7'd10, 32'h0, 1'b0, t1);
    read_wait(1'b0, t1, lat, npch, nwl, nsaen, data);
    chk("t3_data10", 128'(data), 128'(32'hAAAA_5555));
    wait_idle(1'b0);
    do_req(1'b0, 1'b0, 7'd20, 32'h0, 1'b0, t1);
    read_wait(1'b0, t1, lat, npch, nwl, nsaen, data);
    chk("t3_data20", 128'(data), 128'(32'h5A5A_5A5A));
    wait_idle(1'b0);

    // reset during SENSE
    do_req(1'b0, 1'b0, 7'd5, 32'h0, 1'b0, t1);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = saen;
      end
      chk("saen_seen", 128'(seen), 128'(1));
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_wl",       128'(wl),       128'(0));
    chk("mid_rst_saen",     128'(saen),     128'(0));
    chk("mid_rst_pch",      128'(pch),      128'(0));
    chk("mid_rst_rd_data",  128'(rd_data),  128'(0));
    chk("mid_rst_rd_valid", 128'(rd_valid), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready_back", 128'(rq_ready), 128'(1));
    chk("mid_rst_no_rdv",     128'(rd_valid), 128'(0));

    // reparameterised instance: phase lengths and out-of-range row
    do_req(1'b1, 1'b0, 7'd3, 32'h0, 1'b0, t1);
    read_wait(1'b1, t1, lat, npch, nwl, nsaen, data);
    chk("t5_latency", 128'(lat),   128'(9));
    chk("t5_pch_cyc", 128'(npch),  128'(1));
    chk("t5_wl_cyc",  128'(nwl),   128'(7));
    chk("t5_sa_cyc",  128'(nsaen), 128'(3));
    chk("t5_data",    128'(data),  128'(32'hCAFE_F00D));
    wait_idle(1'b1);
    do_req(1'b1, 1'b0, 7'd110, 32'h0, 1'b0, t1);
    read_wait(1'b1, t1, lat, npch, nwl, nsaen, data);
    chk("oor_latency", 128'(lat),  128'(9));
    chk("oor_wl_cyc",  128'(nwl),  128'(0));
    chk("oor_data",    128'(data), 128'(0));
    wait_idle(1'b1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
